// File: rtl/int32_requant_if.sv
// Stream bundle for the int32 -> int8 requantizer: the input beat with its
// per-beat configuration, the output beat, and the saturation debug counter.
// The widths must match the parameters of the int32_requant instance.
interface int32_requant_if #(
    parameter int IN_W    = 32,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 6,
    parameter int OUT_W   = 8,
    parameter int CNT_W   = 16
) ();
    // input side
    logic                      in_valid;
    logic                      in_ready;
    logic signed [IN_W-1:0]    in_data;
    logic                      in_last;
    logic signed [SCALE_W-1:0] cfg_scale;
    logic        [SHIFT_W-1:0] cfg_shift;
    logic signed [OUT_W-1:0]   cfg_zp;

    // output side
    logic                      out_valid;
    logic                      out_ready;
    logic signed [OUT_W-1:0]   out_data;
    logic                      out_last;

    // saturation debug counter
    logic                      sat_clr;
    logic        [CNT_W-1:0]   sat_count;

    // view from the requantizer itself
    modport slave (
        input  in_valid, in_data, in_last, cfg_scale, cfg_shift, cfg_zp,
        input  out_ready, sat_clr,
        output in_ready, out_valid, out_data, out_last, sat_count
    );

    // view from whoever feeds and drains the requantizer
    modport master (
        output in_valid, in_data, in_last, cfg_scale, cfg_shift, cfg_zp,
        output out_ready, sat_clr,
        input  in_ready, out_valid, out_data, out_last, sat_count
    );
endinterface

// File: rtl/int32_requant.sv
// int32 -> int8 requantizer: multiply by a per-beat scale, round-shift
// (half toward +inf), add a zero point and saturate. Three register stages
// that all advance together; a stalled output freezes the whole pipe, and
// in_ready is combinational from out_ready (no skid buffer).
module int32_requant #(
    parameter int IN_W    = 32,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 6,
    parameter int OUT_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    int32_requant_if.slave    bus
);
    localparam int PROD_W = IN_W + SCALE_W;   // full signed product
    localparam int RND_W  = PROD_W + 1;       // product plus rounding term
    localparam int SUM_W  = PROD_W + 2;       // rounded value plus zero point

    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(1 << (OUT_W - 1)));
    localparam logic        [CNT_W-1:0] CNT_MAX = '1;

    // pipeline advance: every stage moves unless a held output is refused
    logic en;

    // stage 1: product with its captured configuration
    logic                      s1_valid;
    logic                      s1_last;
    logic signed [PROD_W-1:0]  s1_prod;
    logic        [SHIFT_W-1:0] s1_shift;
    logic signed [OUT_W-1:0]   s1_zp;

    // stage 2: rounded and shifted value
    logic                      s2_valid;
    logic                      s2_last;
    logic signed [RND_W-1:0]   s2_round;
    logic signed [OUT_W-1:0]   s2_zp;

    // stage 3: output registers
    logic                      s3_valid;
    logic                      s3_last;
    logic signed [OUT_W-1:0]   s3_data;
    logic                      s3_sat;

    logic        [CNT_W-1:0]   sat_count;

    // combinational stage results
    logic signed [IN_W-1:0]    data_in;
    logic signed [SCALE_W-1:0] scale_in;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [RND_W-1:0]   prod_ext;
    logic signed [RND_W-1:0]   round_term;
    logic signed [RND_W-1:0]   round_sum;
    logic signed [RND_W-1:0]   shifted_c;
    logic signed [SUM_W-1:0]   biased_c;
    logic signed [OUT_W-1:0]   clamp_c;
    logic                      sat_c;

    assign en           = ~s3_valid | bus.out_ready;
    assign bus.in_ready = en;

    assign bus.out_valid = s3_valid;
    assign bus.out_data  = s3_data;
    assign bus.out_last  = s3_last;
    assign bus.sat_count = sat_count;

    assign data_in  = bus.in_data;
    assign scale_in = bus.cfg_scale;

    // S1 arithmetic: operands sign-extended to the full product width
    always_comb begin
        prod_c = $signed({{SCALE_W{data_in[IN_W-1]}}, data_in}) *
                 $signed({{IN_W{scale_in[SCALE_W-1]}}, scale_in});
    end

    // S1 register: capture product, shift and zero point of the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
            s1_shift <= '0;
            s1_zp    <= '0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_last  <= bus.in_last;
            s1_prod  <= prod_c;
            s1_shift <= bus.cfg_shift;
            s1_zp    <= bus.cfg_zp;
        end
    end

    // S2 arithmetic: add half an LSB of the result, then arithmetic shift.
    // Shifts at or beyond the product width collapse to the sign fill, since
    // the rounding term alone would otherwise pull small negatives up to 0.
    always_comb begin
        prod_ext   = {s1_prod[PROD_W-1], s1_prod};
        round_term = '0;
        if (s1_shift != '0) begin
            round_term = RND_W'(1) << (s1_shift - SHIFT_W'(1));
        end
        round_sum = prod_ext + round_term;
        if (32'(s1_shift) >= PROD_W) begin
            shifted_c = {RND_W{s1_prod[PROD_W-1]}};
        end else begin
            shifted_c = round_sum >>> s1_shift;
        end
    end

    // S2 register: rounded value travels with its zero point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_round <= '0;
            s2_zp    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_round <= shifted_c;
            s2_zp    <= s1_zp;
        end
    end

    // S3 arithmetic: add zero point with headroom, clamp to the output range
    always_comb begin
        biased_c = {s2_round[RND_W-1], s2_round} +
                   {{(SUM_W - OUT_W){s2_zp[OUT_W-1]}}, s2_zp};
        clamp_c  = biased_c[OUT_W-1:0];
        sat_c    = 1'b0;
        if (biased_c > OUT_MAX) begin
            clamp_c = OUT_MAX[OUT_W-1:0];
            sat_c   = 1'b1;
        end else if (biased_c < OUT_MIN) begin
            clamp_c = OUT_MIN[OUT_W-1:0];
            sat_c   = 1'b1;
        end
    end

    // S3 register: output beat, held while the consumer refuses it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_data  <= '0;
            s3_sat   <= 1'b0;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
            s3_data  <= clamp_c;
            s3_sat   <= sat_c;
        end
    end

    // saturation counter: counts transferred saturated beats, sticks at max,
    // and a clear takes priority over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (bus.sat_clr) begin
            sat_count <= '0;
        end else if (s3_valid && bus.out_ready && s3_sat && (sat_count != CNT_MAX)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_int32_requant.sv
// Bench for int32_requant: directed steps plus randomized beats, every
// output checked against an integer-arithmetic requantization model.
module tb_int32_requant;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int32_requant_if bus ();

    int32_requant dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        bit     last;
        bit     sat;
        int     acc_cyc;
        bit     lat;
    } exp_t;

    exp_t   q[$];
    int     n_pass   = 0;
    int     n_checks = 0;
    int     cyc      = 0;
    bit     mon_on   = 0;
    bit     lat_mode = 0;
    longint exp_cnt  = 0;

    task automatic check(input string tag, input longint obs, input longint expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // requantization computed with ordinary integer arithmetic
    task automatic ref_model(input longint d, input longint sc, input int sh,
                             input longint zp, output longint o, output bit s);
        longint p, r, v, num, den;
        p = d * sc;
        if (sh == 0) r = p;
        else if (sh >= 48) r = (p < 0) ? -1 : 0;
        else begin
            den = longint'(1) << sh;
            num = p + den / 2;
            r = num / den;
            if ((num % den) != 0 && num < 0) r = r - 1;   // floor division
        end
        v = r + zp;
        s = 1'b1;
        if (v > 127) o = 127;
        else if (v < -128) o = -128;
        else begin o = v; s = 1'b0; end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: scoreboard, protocol checks, saturation count model
    bit     prev_stall = 0;
    longint prev_data  = 0;
    bit     prev_last  = 0;
    always begin
        exp_t   e;
        bit     xfer_sat;
        longint mo;
        bit     ms;
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            exp_cnt    = 0;
            prev_stall = 0;
        end else if (mon_on) begin
            check("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            check("sat_count", bus.sat_count, exp_cnt);
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, prev_data);
                check("stall_last", bus.out_last, prev_last);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            xfer_sat = 0;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    e = q.pop_front();
                    check("out_data", bus.out_data, e.data);
                    check("out_last", bus.out_last, e.last);
                    if (e.lat && lat_mode) check("latency", cyc - e.acc_cyc, 3);
                    xfer_sat = e.sat;
                end
            end
            if (bus.sat_clr) exp_cnt = 0;
            else if (xfer_sat && exp_cnt != 65535) exp_cnt++;
            if (bus.in_valid && bus.in_ready) begin
                ref_model(longint'(bus.in_data), longint'(bus.cfg_scale),
                          int'(bus.cfg_shift), longint'(bus.cfg_zp), mo, ms);
                e.data = mo; e.last = bus.in_last; e.sat = ms;
                e.acc_cyc = cyc; e.lat = lat_mode;
                q.push_back(e);
            end
        end
    end

    // present one beat and hold it until accepted (called at posedge+1)
    task automatic send(input longint d, input bit l, input longint sc,
                        input int sh, input longint zp);
        bit acc = 0;
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'(d);
        bus.in_last   = l;
        bus.cfg_scale = 16'(sc);
        bus.cfg_shift = 6'(sh);
        bus.cfg_zp    = 8'(zp);
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, q.size(), 0);
    endtask

    initial begin
        bit done;
        bit seen;
        int n;
        bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0;
        bus.cfg_scale = 0; bus.cfg_shift = 0; bus.cfg_zp = 0;
        bus.out_ready = 1; bus.sat_clr = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_sat_count", bus.sat_count, 0);
        rst_n = 1;
        mon_on = 1;
        lat_mode = 1;

        // T1: pass-through and saturation at both ends
        send(100, 0, 1, 0, 0);
        send(200, 0, 1, 0, 0);
        send(-300, 1, 1, 0, 0);
        drain("t1_drain");
        check("t1_sat_count", bus.sat_count, 2);

        // T2: rounding half toward +inf, huge shift
        send(5, 0, 3, 2, 0);
        send(-6, 0, 3, 2, 0);
        send(2, 0, 3, 2, 0);
        send(-1, 0, 3, 50, 0);
        send(1, 0, 3, 50, 0);
        send(-7, 0, 1, 1, 0);
        drain("t2_drain");

        // T3: zero point and saturation through it
        send(-5, 0, 1, 0, 10);
        send(120, 0, 1, 0, 10);
        send(-1, 0, 1, 0, -128);
        drain("t3_drain");
        lat_mode = 0;

        // T4: 8-beat stream with a 5-cycle output stall in the middle
        fork
            for (int i = 1; i <= 8; i++) send(i, (i == 8), 1, 0, 0);
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1;
            end
        join
        drain("t4_drain");

        // T5: per-beat scale alternating 1/2 under random backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) send(10, 0, (i % 2) ? 2 : 1, 0, 0);
                done = 1;
            end
            while (!done) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        join
        bus.out_ready = 1;
        drain("t5_drain");

        // randomized beats and config under random backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++)
                    send(longint'($signed($urandom)), 1'($urandom_range(0, 1)),
                         longint'($signed(16'($urandom))), $urandom_range(0, 63),
                         longint'($signed(8'($urandom))));
                done = 1;
            end
            while (!done) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
        join
        bus.out_ready = 1;
        drain("rand_drain");

        // T6: counter clear, saturation at max, clear beating a concurrent increment
        bus.sat_clr = 1;
        @(posedge clk);
        #1 bus.sat_clr = 0;
        check("clr_idle", bus.sat_count, 0);
        for (int i = 0; i < 65538; i++) send(1000, 0, 1, 0, 0);
        drain("flood_drain");
        check("sat_stick", bus.sat_count, 65535);
        send(-1000, 0, 1, 0, 0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        seen = bus.out_valid;
        check("clr_beat_seen", seen, 1);
        bus.sat_clr = 1;
        @(posedge clk);
        #1 bus.sat_clr = 0;
        check("clr_wins", bus.sat_count, 0);

        // reset in the middle of a stream
        bus.in_valid = 1; bus.in_data = 1000; bus.in_last = 0;
        bus.cfg_scale = 1; bus.cfg_shift = 0; bus.cfg_zp = 0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_busy", bus.out_valid, 1);
        rst_n = 0;
        bus.in_valid = 0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        check("midrst_sat_count", bus.sat_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check("ready_after_reset", bus.in_ready, 1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        @(posedge clk);
        #1;
        check("post_reset_quiet", seen, 0);
        send(-7, 1, 1, 0, 0);
        drain("post_reset_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
